// File: rtl/frame_cfg_writer.sv
// frame_cfg_writer: column configuration frame initiator.
// Takes a valid/ready stream of 32-bit words. Each frame is a header
// (sync FAB0, column, frame index) followed by one word per tile row.
// The writer assembles the rows into FrameData and then fires a one-cycle
// one-hot FrameStrobe.
// Optional feature macro: FRAME_CFG_PARITY_EN. When it is defined, every frame
// carries an XOR trailer word that is checked in a CHECK state before the strobe.
module frame_cfg_writer #(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int NumRows         = 16,
  parameter int ColumnID        = 0
) (
  input  logic                                 UserCLK,
  input  logic                                 resetn,
  input  logic [FrameBitsPerRow-1:0]           s_data,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  input  logic                                 err_clr,
  output logic [NumRows*FrameBitsPerRow-1:0]   FrameData,
  output logic [MaxFramesPerCol-1:0]           FrameStrobe,
  output logic                                 busy,
  output logic [15:0]                          frames_written,
  output logic                                 err_sticky
);

  localparam logic [15:0] SyncWord = 16'hFAB0;
`ifdef FRAME_CFG_PARITY_EN
  localparam int SkipWords = NumRows + 1;
`else
  localparam int SkipWords = NumRows;
`endif
  localparam int RowW = $clog2(SkipWords + 1);

`ifdef FRAME_CFG_PARITY_EN
  typedef enum logic [2:0] {IDLE, DATA, SKIP, STROBE, CHECK} state_t;
`else
  typedef enum logic [1:0] {IDLE, DATA, SKIP, STROBE} state_t;
`endif

  state_t                      state_reg, state_next;
  logic [RowW-1:0]             row_cnt_reg, row_cnt_next;
  logic [7:0]                  index_reg, index_next;
  logic                        err_set;
  logic                        wr_en;
  logic                        accept;
  logic [FrameBitsPerRow-1:0]  row_reg [NumRows];
`ifdef FRAME_CFG_PARITY_EN
  logic [FrameBitsPerRow-1:0]  parity_reg, parity_next;
`endif

  // s_ready is a register that mirrors "not in STROBE", so accept is a clean AND.
  assign accept = s_valid & s_ready;

  // Next-state logic: header decode, row counting and error detection.
  always_comb begin
    state_next   = state_reg;
    row_cnt_next = row_cnt_reg;
    index_next   = index_reg;
    err_set      = 1'b0;
    wr_en        = 1'b0;
`ifdef FRAME_CFG_PARITY_EN
    parity_next  = parity_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (accept) begin
          row_cnt_next = '0;
          if (s_data[31:16] != SyncWord) begin
            err_set = 1'b1;
          end else if (s_data[15:8] != 8'(ColumnID)) begin
            state_next = SKIP;
          end else if (int'(s_data[7:0]) >= MaxFramesPerCol) begin
            state_next = SKIP;
            err_set    = 1'b1;
          end else begin
            index_next = s_data[7:0];
            state_next = DATA;
`ifdef FRAME_CFG_PARITY_EN
            parity_next = '0;
`endif
          end
        end
      end
      DATA: begin
        if (accept) begin
          wr_en = 1'b1;
`ifdef FRAME_CFG_PARITY_EN
          parity_next = parity_reg ^ s_data;
`endif
          if (row_cnt_reg == RowW'(NumRows - 1)) begin
            row_cnt_next = '0;
`ifdef FRAME_CFG_PARITY_EN
            state_next   = CHECK;
`else
            state_next   = STROBE;
`endif
          end else begin
            row_cnt_next = row_cnt_reg + 1'b1;
          end
        end
      end
      SKIP: begin
        if (accept) begin
          if (row_cnt_reg == RowW'(SkipWords - 1)) begin
            row_cnt_next = '0;
            state_next   = IDLE;
          end else begin
            row_cnt_next = row_cnt_reg + 1'b1;
          end
        end
      end
`ifdef FRAME_CFG_PARITY_EN
      CHECK: begin
        if (accept) begin
          if (s_data == parity_reg) begin
            state_next = STROBE;
          end else begin
            state_next = IDLE;
            err_set    = 1'b1;
          end
        end
      end
`endif
      STROBE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register and all registered status outputs derived from the next state.
  always_ff @(posedge UserCLK) begin
    if (!resetn) begin
      state_reg      <= IDLE;
      row_cnt_reg    <= '0;
      index_reg      <= '0;
      s_ready        <= 1'b1;
      busy           <= 1'b0;
      FrameStrobe    <= '0;
      frames_written <= '0;
      err_sticky     <= 1'b0;
`ifdef FRAME_CFG_PARITY_EN
      parity_reg     <= '0;
`endif
    end else begin
      state_reg   <= state_next;
      row_cnt_reg <= row_cnt_next;
      index_reg   <= index_next;
      s_ready     <= (state_next != STROBE);
      busy        <= (state_next != IDLE);
      FrameStrobe <= (state_next == STROBE)
                     ? ({{(MaxFramesPerCol-1){1'b0}}, 1'b1} << index_next)
                     : '0;
      if (state_next == STROBE)
        frames_written <= frames_written + 16'd1;
      // A set event in the same cycle as err_clr keeps the flag set.
      if (err_set)
        err_sticky <= 1'b1;
      else if (err_clr)
        err_sticky <= 1'b0;
`ifdef FRAME_CFG_PARITY_EN
      parity_reg <= parity_next;
`endif
    end
  end

  // One register per row slice, loaded when the data word for that row arrives.
  for (genvar gi = 0; gi < NumRows; gi++) begin : g_row
    always_ff @(posedge UserCLK) begin
      if (!resetn)
        row_reg[gi] <= '0;
      else if (wr_en && row_cnt_reg == RowW'(gi))
        row_reg[gi] <= s_data;
    end
    assign FrameData[gi*FrameBitsPerRow +: FrameBitsPerRow] = row_reg[gi];
  end

endmodule

// File: tb/tb_frame_cfg_writer.sv
// tb_frame_cfg_writer: randomized scoreboard bench for frame_cfg_writer.
// The stimulus side models frames at transaction level and queues the expected
// strobes. A negedge monitor pops the queue whenever FrameStrobe fires.
module tb_frame_cfg_writer;

  localparam int NR   = 16;
  localparam int MAXF = 20;
  localparam int COL  = 0;
`ifdef FRAME_CFG_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic [31:0]       s_data = '0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic              err_clr = 1'b0;
  logic [NR*32-1:0]  FrameData;
  logic [MAXF-1:0]   FrameStrobe;
  logic              busy;
  logic [15:0]       frames_written;
  logic              err_sticky;

  frame_cfg_writer #(.MaxFramesPerCol(MAXF), .FrameBitsPerRow(32), .NumRows(NR), .ColumnID(COL)) dut (
    .UserCLK(clk), .resetn(resetn), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .err_clr(err_clr), .FrameData(FrameData), .FrameStrobe(FrameStrobe), .busy(busy),
    .frames_written(frames_written), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int               idx;
    logic [NR*32-1:0] fd;
    logic [15:0]      cnt;
    int               cyc;
    int               hdr_cyc;
    bit               gapless;
  } exp_t;

  exp_t sb[$];
  int   strobe_log[$];

  // Transaction-level model state.
  logic [NR*32-1:0] model_fd = '0;
  logic [15:0]      model_cnt = '0;
  bit               model_err = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input bit ok, input string detail);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  function automatic int gap_for(input int gmode);
    if (gmode == 1) return 1;
    if (gmode == 2) return int'($urandom_range(0, 3));
    return 0;
  endfunction

  // Drive one word after an optional idle gap; returns the monitor-cycle count
  // seen just before the accepting edge.
  task automatic send_word(input logic [31:0] w, input int gap, output int acc);
    bit ok;
    int waited;
    s_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    s_valid = 1'b1;
    s_data  = w;
    waited  = 0;
    acc     = 0;
    forever begin
      @(negedge clk);
      ok  = s_ready;
      acc = cyc;
      @(posedge clk); #1;
      if (ok) break;
      waited++;
      if (waited > 50) begin
        chk("ready_timeout", 1'b0, $sformatf("s_ready low for %0d cycles, required accept", waited));
        break;
      end
    end
    s_valid = 1'b0;
  endtask

  // Send a frame. limit >= 0 stops after that many data words (used for the abort case).
  task automatic send_frame(input logic [15:0] sync, input logic [7:0] col, input logic [7:0] idx,
                            input logic [31:0] base, input bit rnd, input int gmode, input int limit);
    logic [31:0]      w;
    logic [31:0]      par;
    logic [NR*32-1:0] fd;
    int               acc, hdr_acc;
    bit               good;
    exp_t             e;
    good = (sync == 16'hFAB0) && (int'(col) == COL) && (int'(idx) < MAXF);
    send_word({sync, col, idx}, gap_for(gmode), hdr_acc);
    if (sync != 16'hFAB0) begin
      model_err = 1'b1;
      return;
    end
    if (int'(col) == COL && int'(idx) >= MAXF) model_err = 1'b1;
    par = '0;
    fd  = model_fd;
    acc = hdr_acc;
    for (int r = 0; r < NR; r++) begin
      if (limit >= 0 && r >= limit) return;
      w = rnd ? $urandom : base + 32'(r);
      send_word(w, gap_for(gmode), acc);
      par = par ^ w;
      fd[r*32 +: 32] = w;
    end
    if (PAR != 0) send_word(par, gap_for(gmode), acc);
    if (good) begin
      model_fd  = fd;
      model_cnt = model_cnt + 16'd1;
      e.idx = int'(idx); e.fd = fd; e.cnt = model_cnt;
      e.cyc = acc + 1; e.hdr_cyc = hdr_acc; e.gapless = (gmode == 0);
      sb.push_back(e);
    end
  endtask

  // Compare quiet-time status against the model after the pipeline settles.
  task automatic check_idle(input string tag);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk({tag, "_busy"}, busy == 1'b0, $sformatf("busy=%0b, required 0", busy));
    chk({tag, "_err"}, err_sticky == model_err, $sformatf("err_sticky=%0b, required %0b", err_sticky, model_err));
    chk({tag, "_fd"}, FrameData == model_fd, $sformatf("FrameData=%h, required %h", FrameData, model_fd));
    chk({tag, "_cnt"}, frames_written == model_cnt, $sformatf("frames_written=%0d, required %0d", frames_written, model_cnt));
    @(posedge clk); #1;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    model_err = 1'b0;
  endtask

  task automatic do_reset();
    resetn  = 1'b0;
    s_valid = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    model_fd = '0; model_cnt = '0; model_err = 1'b0;
  endtask

  // Monitor: per-cycle invariants and scoreboard pop on every strobe.
  always @(negedge clk) begin
    logic [MAXF-1:0] es;
    exp_t e;
    if (resetn) begin
      chk("onehot", $countones(FrameStrobe) <= 1, $sformatf("FrameStrobe=%h, required at most one bit", FrameStrobe));
      chk("ready_vs_strobe", s_ready == (FrameStrobe == '0),
          $sformatf("s_ready=%0b with FrameStrobe=%h, required low only in strobe cycle", s_ready, FrameStrobe));
      if (FrameStrobe != '0) begin
        strobe_log.push_back(cyc);
        if (sb.size() == 0) begin
          chk("unexpected_strobe", 1'b0, $sformatf("FrameStrobe=%h at cycle %0d, required none", FrameStrobe, cyc));
        end else begin
          e = sb.pop_front();
          es = '0;
          es[e.idx] = 1'b1;
          chk("strobe", FrameStrobe == es, $sformatf("FrameStrobe=%h, required %h", FrameStrobe, es));
          chk("strobe_fd", FrameData == e.fd, $sformatf("FrameData=%h, required %h", FrameData, e.fd));
          chk("strobe_cnt", frames_written == e.cnt, $sformatf("frames_written=%0d, required %0d", frames_written, e.cnt));
          chk("strobe_busy", busy == 1'b1, $sformatf("busy=%0b, required 1", busy));
          chk("strobe_latency", cyc == e.cyc, $sformatf("strobe cycle=%0d, required %0d", cyc, e.cyc));
          if (e.gapless)
            chk("hdr_to_strobe", cyc - e.hdr_cyc == NR + 1 + PAR,
                $sformatf("header-to-strobe=%0d, required %0d", cyc - e.hdr_cyc, NR + 1 + PAR));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, n;
    logic [15:0] sy;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("rst_ready", s_ready == 1'b1, $sformatf("s_ready=%0b, required 1", s_ready));
    chk("rst_strobe", FrameStrobe == '0, $sformatf("FrameStrobe=%h, required 0", FrameStrobe));
    chk("rst_fd", FrameData == '0, $sformatf("FrameData=%h, required 0", FrameData));
    chk("rst_busy", busy == 1'b0, $sformatf("busy=%0b, required 0", busy));
    chk("rst_cnt", frames_written == 16'd0, $sformatf("frames_written=%0d, required 0", frames_written));
    chk("rst_err", err_sticky == 1'b0, $sformatf("err_sticky=%0b, required 0", err_sticky));
    @(posedge clk); #1;

    // Directed frame to index 3.
    send_frame(16'hFAB0, 8'd0, 8'd3, 32'h1000_0000, 1'b0, 0, -1);
    check_idle("frame3");
    // Foreign column: consumed silently.
    send_frame(16'hFAB0, 8'd1, 8'd5, 32'h2000_0000, 1'b0, 0, -1);
    check_idle("col1");
    // Bad sync, then a good frame, then clear.
    send_frame(16'h1234, 8'd0, 8'd0, 32'h0, 1'b0, 0, -1);
    check_idle("badsync");
    send_frame(16'hFAB0, 8'd0, 8'd7, 32'h0, 1'b1, 0, -1);
    check_idle("after_bad");
    pulse_clr();
    check_idle("clr1");
    // Out-of-range index.
    send_frame(16'hFAB0, 8'd0, 8'd20, 32'h3000_0000, 1'b0, 0, -1);
    check_idle("idx20");
    pulse_clr();
    // Toggling s_valid, then an aborted frame.
    send_frame(16'hFAB0, 8'd0, 8'd2, 32'h4000_0000, 1'b0, 1, -1);
    check_idle("toggle");
    send_frame(16'hFAB0, 8'd0, 8'd9, 32'h5000_0000, 1'b0, 0, 8);
    do_reset();
    check_idle("abort");
    // Back-to-back frames to indices 0 and 19.
    n = strobe_log.size();
    send_frame(16'hFAB0, 8'd0, 8'd0, 32'h6000_0000, 1'b0, 0, -1);
    send_frame(16'hFAB0, 8'd0, 8'd19, 32'h7000_0000, 1'b0, 0, -1);
    check_idle("b2b");
    if (strobe_log.size() == n + 2)
      chk("b2b_spacing", strobe_log[n+1] - strobe_log[n] == NR + 2 + PAR,
          $sformatf("strobe spacing=%0d, required %0d", strobe_log[n+1] - strobe_log[n], NR + 2 + PAR));
    else
      chk("b2b_count", 1'b0, $sformatf("strobes=%0d, required 2", strobe_log.size() - n));

    // Randomized mix of frame kinds and gap patterns.
    for (int i = 0; i < 30; i++) begin
      k = int'($urandom_range(0, 9));
      case (k)
        0: begin
          sy = 16'($urandom);
          if (sy == 16'hFAB0) sy = 16'hFAB1;
          send_frame(sy, 8'd0, 8'($urandom), 32'h0, 1'b1, 2, -1);
        end
        1: send_frame(16'hFAB0, 8'($urandom_range(1, 255)), 8'($urandom_range(0, 19)), 32'h0, 1'b1, 2, -1);
        2: send_frame(16'hFAB0, 8'd0, 8'($urandom_range(20, 255)), 32'h0, 1'b1, 2, -1);
        default: send_frame(16'hFAB0, 8'd0, 8'($urandom_range(0, 19)), 32'h0, 1'b1, int'($urandom_range(0, 2)), -1);
      endcase
      if ($urandom_range(0, 4) == 0) begin
        check_idle("rand");
        pulse_clr();
      end
    end
    check_idle("rand_end");
    chk("sb_empty", sb.size() == 0, $sformatf("pending strobes=%0d, required 0", sb.size()));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
